// File: rtl/mfp_uart_transmitter_pkg.sv
// Shared UART configuration: baud divider, serializer state encoding,
// and default FIFO sizing used by the transmit and receive paths.
package mfp_uart_transmitter_pkg;

  localparam int DEFAULT_FIFO_DEPTH_LOG2 = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  // Rounded clocks-per-bit
  function automatic int baud_divider(
    input int clk_hz,
    input int baud
  );
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/mfp_uart_transmitter_if.sv
// Byte write port of the UART transmitter: CPU-side push plus
// FIFO status.
interface mfp_uart_transmitter_if #(
  parameter int FIFO_DEPTH_LOG2 = 4
);

  logic                     wr_en;
  logic [7:0]               wr_data;
  logic                     full;
  logic                     empty;
  logic [FIFO_DEPTH_LOG2:0] level;
  logic                     overflow;

  modport master (
    output wr_en,
    output wr_data,
    input  full,
    input  empty,
    input  level,
    input  overflow
  );

  modport slave (
    input  wr_en,
    input  wr_data,
    output full,
    output empty,
    output level,
    output overflow
  );

endinterface

// File: rtl/mfp_uart_fifo.sv
// Synchronous single-clock FIFO with registered full/empty/level
// and a sticky overflow flag.
module mfp_uart_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      data_out,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL =
    {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   level_n;
  logic                  push_ok;
  logic                  pop_ok;

  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  assign data_out = mem[rd_ptr];

  always_comb begin
    level_n = level;
    if (push_ok && !pop_ok) begin
      level_n = level + 1'b1;
    end else if (!push_ok && pop_ok) begin
      level_n = level - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      // Drop-on-full uses the registered flag, never a same-cycle pop
      if (push && full) overflow <= 1'b1;
      level <= level_n;
      full  <= (level_n == FULL_LEVEL);
      empty <= (level_n == '0);
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mfp_uart_transmitter.sv
// 8N1 UART transmitter: byte FIFO feeding a baud-timed serializer
// with a registered tx output.
module mfp_uart_transmitter
  import mfp_uart_transmitter_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int BAUD_RATE       = 115200,
  parameter int FIFO_DEPTH_LOG2 = DEFAULT_FIFO_DEPTH_LOG2
) (
  input  logic                   clock,
  input  logic                   resetn,
  mfp_uart_transmitter_if.slave  bus,
  output logic                   busy,
  output logic                   tx
);

  localparam int DIVIDER =
    baud_divider(CLOCK_FREQUENCY, BAUD_RATE);
  localparam int CNT_W = (DIVIDER > 2) ? $clog2(DIVIDER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDER - 1);

  tx_state_t        state;
  tx_state_t        state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [7:0]       shift;
  logic [7:0]       shift_n;
  logic [2:0]       bit_idx;
  logic [2:0]       bit_n;
  logic             tx_n;
  logic             pop;
  logic             baud_done;
  logic [7:0]       fifo_data;

  mfp_uart_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clock     (clock),
    .resetn    (resetn),
    .push      (bus.wr_en),
    .push_data (bus.wr_data),
    .pop       (pop),
    .data_out  (fifo_data),
    .full      (bus.full),
    .empty     (bus.empty),
    .level     (bus.level),
    .overflow  (bus.overflow)
  );

  assign baud_done = (cnt == CNT_LAST);
  assign busy      = (state != ST_IDLE);

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    shift_n = shift;
    bit_n   = bit_idx;
    tx_n    = 1'b1;
    pop     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        cnt_n = '0;
        if (!bus.empty) begin
          pop     = 1'b1;
          shift_n = fifo_data;
          state_n = ST_START;
        end
      end
      ST_START: begin
        tx_n = 1'b0;
        if (baud_done) begin
          cnt_n   = '0;
          bit_n   = '0;
          state_n = ST_DATA;
        end
      end
      ST_DATA: begin
        tx_n = shift[0];
        if (baud_done) begin
          cnt_n   = '0;
          shift_n = shift >> 1;
          bit_n   = bit_idx + 1'b1;
          if (bit_idx == 3'd7) state_n = ST_STOP;
        end
      end
      ST_STOP: begin
        if (baud_done) begin
          cnt_n   = '0;
          state_n = ST_IDLE;
        end
      end
    endcase
  end

  // tx follows the state one clock later, from a flop
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      shift   <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      shift   <= shift_n;
      bit_idx <= bit_n;
      tx      <= tx_n;
    end
  end

endmodule

// File: tb/tb_mfp_uart_transmitter.sv
// Scoreboard bench: directed writes queue expected bytes, a line
// decoder on tx pops and compares each received frame.
module tb_mfp_uart_transmitter;

  localparam int CLK_HZ = 1000000;
  localparam int BAUD   = 100000;
  localparam int LOG2   = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic busy;
  logic tx;

  always #5 clk = ~clk;

  mfp_uart_transmitter_if #(.FIFO_DEPTH_LOG2(LOG2)) bus();

  mfp_uart_transmitter #(
    .CLOCK_FREQUENCY (CLK_HZ),
    .BAUD_RATE       (BAUD),
    .FIFO_DEPTH_LOG2 (LOG2)
  ) dut (
    .clock  (clk),
    .resetn (resetn),
    .bus    (bus),
    .busy   (busy),
    .tx     (tx)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  int start_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act,
                       input int req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Line decoder, samples mid-bit on the falling clock edge
  int mstate = 0;
  int mcnt = 0;
  logic [7:0] mbyte = '0;
  logic prev_tx = 1'b1;
  bit mon_abort = 1'b0;

  always @(negedge clk) begin
    if (mon_abort) begin
      mstate = 0;
      mon_abort = 1'b0;
    end else if (mstate == 0) begin
      if (prev_tx === 1'b1 && tx === 1'b0) begin
        mstate = 1;
        mcnt = 0;
        start_cyc.push_back(cyc);
      end
    end else begin
      mcnt++;
      if (mcnt == 5) begin
        check("start_bit", int'(tx), 0);
      end else if (mcnt >= 15 && mcnt <= 85 && mcnt % 10 == 5) begin
        mbyte[(mcnt - 15) / 10] = tx;
      end else if (mcnt == 95) begin
        check("stop_bit", int'(tx), 1);
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_frame: got 0x%02h, expected none",
                   mbyte);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (mbyte !== e) begin
            n_fail++;
            $display("FAIL frame_byte: got 0x%02h, expected 0x%02h",
                     mbyte, e);
          end
        end
        mstate = 0;
      end
    end
    prev_tx = tx;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] d, input bit store);
    bus.wr_en = 1'b1;
    bus.wr_data = d;
    if (store) exp_q.push_back(d);
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    bus.wr_en = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while (!(exp_q.size() == 0 && !busy && bus.empty) && k < budget) begin
      tick();
      k++;
    end
    check("drain_in_time", int'(k < budget), 1);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int idx;
    int edges;
    logic last;
    bus.wr_en = 1'b0;
    bus.wr_data = '0;

    // Reset state
    resetn = 1'b0;
    tick();
    tick();
    check("rst_tx", int'(tx), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_empty", int'(bus.empty), 1);
    check("rst_full", int'(bus.full), 0);
    check("rst_level", int'(bus.level), 0);
    check("rst_overflow", int'(bus.overflow), 0);
    resetn = 1'b1;
    tick();

    // Single byte latency and frame length
    write_byte(8'h55, 1'b1);
    check("t1_empty_after_wr", int'(bus.empty), 0);
    check("t1_level_after_wr", int'(bus.level), 1);
    tick();
    check("t1_busy_after_pop", int'(busy), 1);
    check("t1_empty_after_pop", int'(bus.empty), 1);
    check("t1_tx_still_high", int'(tx), 1);
    tick();
    check("t1_tx_falls", int'(tx), 0);
    k = 0;
    while (busy && k < 200) begin
      tick();
      k++;
    end
    check("t1_busy_length", k, 99);
    wait_drain(300);

    // Back-to-back frames
    idx = start_cyc.size();
    write_byte(8'hA3, 1'b1);
    check("t2_level_first", int'(bus.level), 1);
    write_byte(8'h0F, 1'b1);
    check("t2_level_push_pop", int'(bus.level), 1);
    k = 0;
    while (bus.level != 0 && k < 300) begin
      tick();
      k++;
    end
    check("t2_level_zero", int'(bus.level), 0);
    wait_drain(400);
    check("t2_frames", start_cyc.size() - idx, 2);
    if (start_cyc.size() - idx == 2)
      check("t2_start_spacing",
            start_cyc[idx + 1] - start_cyc[idx], 101);

    // Fill and overflow
    write_byte(8'hB0, 1'b1);
    for (int i = 0; i < 17; i++) begin
      write_byte(8'hC0 + 8'(i), i < 16);
      if (i == 15) begin
        check("t3_level_full", int'(bus.level), 16);
        check("t3_full", int'(bus.full), 1);
        check("t3_no_overflow_yet", int'(bus.overflow), 0);
      end
      if (i == 16) begin
        check("t3_overflow", int'(bus.overflow), 1);
        check("t3_level_kept", int'(bus.level), 16);
      end
    end
    wait_drain(2500);
    check("t3_overflow_sticky", int'(bus.overflow), 1);

    do_reset();
    check("t4_overflow_cleared", int'(bus.overflow), 0);

    // Write at full in the same cycle as the IDLE pop
    write_byte(8'hB1, 1'b1);
    for (int i = 0; i < 16; i++) write_byte(8'hD0 + 8'(i), 1'b1);
    check("t4_full", int'(bus.full), 1);
    k = 0;
    while (busy && k < 200) begin
      tick();
      k++;
    end
    check("t4_idle_found", int'(busy), 0);
    write_byte(8'hEE, 1'b0);
    check("t4_level_after", int'(bus.level), 15);
    check("t4_overflow", int'(bus.overflow), 1);
    check("t4_not_full", int'(bus.full), 0);
    wait_drain(2500);

    // Reset during data bit 3
    write_byte(8'h5A, 1'b1);
    k = 0;
    while (!(mstate == 1 && mcnt >= 43) && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("t5_reached_bit3", int'(k < 300), 1);
    #1;
    resetn = 1'b0;
    mon_abort = 1'b1;
    exp_q.delete();
    tick();
    check("t5_tx", int'(tx), 1);
    check("t5_busy", int'(busy), 0);
    check("t5_level", int'(bus.level), 0);
    check("t5_overflow", int'(bus.overflow), 0);
    check("t5_empty", int'(bus.empty), 1);
    resetn = 1'b1;
    edges = 0;
    last = tx;
    repeat (150) begin
      tick();
      if (tx !== last) edges++;
      last = tx;
    end
    check("t5_tx_quiet", edges, 0);

    // Pointer wrap with 40 paced bytes
    for (int i = 0; i < 40; i++) begin
      k = 0;
      while (bus.level >= 4 && k < 500) begin
        tick();
        k++;
      end
      check("t6_level_bound", int'(bus.level <= 5), 1);
      write_byte(8'(i), 1'b1);
    end
    wait_drain(5000);
    check("t6_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
